// File: rtl/i2s_frame_capture_if.sv
// Sample input and RAM write bus of the I2S capture stage.
// slave: capture block view; master: source/RAM-side view.
interface i2s_frame_capture_if #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10
);
  logic [DATA_BITS-1:0] sample_l_i;
  logic [DATA_BITS-1:0] sample_r_i;
  logic                 data_ready_i;
  logic                 wr_en_o;
  logic [ADDR_BITS:0]   wr_addr_o;
  logic [DATA_BITS-1:0] wr_data_o;

  modport slave (
    input  sample_l_i, sample_r_i, data_ready_i,
    output wr_en_o, wr_addr_o, wr_data_o
  );

  modport master (
    output sample_l_i, sample_r_i, data_ready_i,
    input  wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/i2s_frame_capture.sv
// I2S L/R capture into a two-bank RAM with mode, decimation, release handshake.
// Ports: bclk/rst_n, bus (samples in, RAM write out), mode/decim/release/clear in, frame status out.
module i2s_frame_capture #(
  parameter int DATA_BITS  = 16,
  parameter int ADDR_BITS  = 10,
  parameter int DECIM_BITS = 4
) (
  input  logic                  bclk,
  input  logic                  rst_n,
  i2s_frame_capture_if.slave    bus,
  input  logic [1:0]            mode_i,
  input  logic [DECIM_BITS-1:0] decim_i,
  input  logic                  release_toggle_i,
  input  logic                  clear_overrun_i,
  output logic                  frame_toggle_o,
  output logic                  frame_bank_o,
  output logic                  active_bank_o,
  output logic                  overrun_o
);

  typedef enum logic [1:0] {FILL, WR_R, STALL} state_t;

  localparam logic [ADDR_BITS-1:0] PMAX = '1;

  state_t r_state, w_state_nx;

  logic [1:0]            r_mode_s1, r_mode_s2, r_mode_act;
  logic [DECIM_BITS-1:0] r_decim_s1, r_decim_s2, r_decim_act;
  logic                  r_rel_s1, r_rel_s2, r_rel_d;
  logic [DECIM_BITS-1:0] r_dcnt;
  logic [ADDR_BITS-1:0]  r_ptr;
  logic                  r_bank, r_relp, r_done;
  logic [1:0]            r_full;
  logic [DATA_BITS-1:0]  r_hold;
  logic                  r_wr_en;
  logic [ADDR_BITS:0]    r_wr_addr;
  logic [DATA_BITS-1:0]  r_wr_data;
  logic                  r_toggle, r_fbank, r_ovr;

  logic                  w_ld, w_rel_ok;
  logic [1:0]            w_mode;
  logic [DECIM_BITS-1:0] w_decim;
  logic [1:0]            w_full_rel;
  logic [DATA_BITS-1:0]  w_l, w_r, w_avg, w_wdata;
  logic                  w_acc, w_dec, w_wr, w_last, w_ovr_set;

  assign w_l = bus.sample_l_i;
  assign w_r = bus.sample_r_i;

  // floor((L+R)/2) from halves: no adder wider than the sample needed
  assign w_avg = {w_l[DATA_BITS-1], w_l[DATA_BITS-1:1]}
               + {w_r[DATA_BITS-1], w_r[DATA_BITS-1:1]}
               + DATA_BITS'(w_l[0] & w_r[0]);

  // mode/decim follow the synced inputs only at a bank start
  assign w_ld    = (r_state == FILL) && (r_ptr == '0);
  assign w_mode  = w_ld ? r_mode_s2  : r_mode_act;
  assign w_decim = w_ld ? r_decim_s2 : r_decim_act;

  assign w_rel_ok = (r_rel_s2 ^ r_rel_d) && r_full[r_relp];

  // release is applied before any same-cycle completion
  always_comb begin
    w_full_rel = r_full;
    if (w_rel_ok) w_full_rel[r_relp] = 1'b0;
  end

  always_comb begin
    w_state_nx = r_state;
    w_acc      = 1'b0;
    w_dec      = 1'b0;
    w_wr       = 1'b0;
    w_wdata    = '0;
    w_last     = 1'b0;
    w_ovr_set  = 1'b0;
    unique case (r_state)
      FILL: begin
        if (r_done) begin
          w_state_nx = w_full_rel[~r_bank] ? STALL : FILL;
        end else if (bus.data_ready_i) begin
          if (r_dcnt == '0) begin
            w_acc = 1'b1;
            w_wr  = 1'b1;
            unique case (w_mode)
              2'd0:    w_wdata = w_l;
              2'd1:    w_wdata = w_r;
              2'd2:    w_wdata = w_avg;
              default: w_wdata = w_l;
            endcase
            if (w_mode == 2'd3) w_state_nx = WR_R;
            else w_last = (r_ptr == PMAX);
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      WR_R: begin
        w_wr       = 1'b1;
        w_wdata    = r_hold;
        w_last     = (r_ptr == PMAX);
        w_state_nx = FILL;
      end
      STALL: begin
        w_ovr_set = bus.data_ready_i;
        if (w_rel_ok && !w_full_rel[r_bank]) w_state_nx = FILL;
      end
      default: w_state_nx = FILL;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      r_mode_s1   <= '0;
      r_mode_s2   <= '0;
      r_mode_act  <= '0;
      r_decim_s1  <= '0;
      r_decim_s2  <= '0;
      r_decim_act <= '0;
      r_rel_s1    <= 1'b0;
      r_rel_s2    <= 1'b0;
      r_rel_d     <= 1'b0;
      r_dcnt      <= '0;
      r_ptr       <= '0;
      r_bank      <= 1'b0;
      r_relp      <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= '0;
      r_hold      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_toggle    <= 1'b0;
      r_fbank     <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_mode_s1  <= mode_i;
      r_mode_s2  <= r_mode_s1;
      r_decim_s1 <= decim_i;
      r_decim_s2 <= r_decim_s1;
      r_rel_s1   <= release_toggle_i;
      r_rel_s2   <= r_rel_s1;
      r_rel_d    <= r_rel_s2;

      if (w_ld) begin
        r_mode_act  <= r_mode_s2;
        r_decim_act <= r_decim_s2;
      end

      if (w_acc) begin
        r_dcnt <= w_decim;
        r_hold <= w_r;
      end else if (w_dec) begin
        r_dcnt <= r_dcnt - DECIM_BITS'(1);
      end

      r_wr_en <= w_wr;
      if (w_wr) begin
        r_wr_addr <= {r_bank, r_ptr};
        r_wr_data <= w_wdata;
        r_ptr     <= r_ptr + ADDR_BITS'(1);
      end
      r_done <= w_last;

      r_full <= w_full_rel;
      if (w_rel_ok) r_relp <= ~r_relp;

      if (r_done) begin
        r_toggle       <= ~r_toggle;
        r_fbank        <= r_bank;
        r_full[r_bank] <= 1'b1;
        r_bank         <= ~r_bank;
        r_ptr          <= '0;
        r_dcnt         <= '0;
      end

      if (w_ovr_set)            r_ovr <= 1'b1;
      else if (clear_overrun_i) r_ovr <= 1'b0;
    end
  end

  assign bus.wr_en_o   = r_wr_en;
  assign bus.wr_addr_o = r_wr_addr;
  assign bus.wr_data_o = r_wr_data;
  assign frame_toggle_o = r_toggle;
  assign frame_bank_o   = r_fbank;
  assign active_bank_o  = r_bank;
  assign overrun_o      = r_ovr;

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Directed bench for i2s_frame_capture with DEPTH 8.
// Logs RAM writes at negedge and checks them against hand-computed values.
module tb_i2s_frame_capture;
  localparam int DB = 16;
  localparam int AB = 3;
  localparam int XB = 4;

  logic          bclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic [XB-1:0] decim_i = '0;
  logic          release_toggle_i = 1'b0;
  logic          clear_overrun_i = 1'b0;
  logic          frame_toggle_o, frame_bank_o, active_bank_o, overrun_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AB:0]   qa[$];
  logic [DB-1:0] qd[$];
  int            qc[$];

  i2s_frame_capture_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus();

  i2s_frame_capture #(
    .DATA_BITS(DB), .ADDR_BITS(AB), .DECIM_BITS(XB)
  ) dut (
    .bclk(bclk),
    .rst_n(rst_n),
    .bus(bus),
    .mode_i(mode_i),
    .decim_i(decim_i),
    .release_toggle_i(release_toggle_i),
    .clear_overrun_i(clear_overrun_i),
    .frame_toggle_o(frame_toggle_o),
    .frame_bank_o(frame_bank_o),
    .active_bank_o(active_bank_o),
    .overrun_o(overrun_o)
  );

  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc++;

  always @(negedge bclk)
    if (rst_n && bus.wr_en_o) begin
      qa.push_back(bus.wr_addr_o);
      qd.push_back(bus.wr_data_o);
      qc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge bclk);
  endtask

  task automatic frame(input logic [DB-1:0] l, input logic [DB-1:0] r);
    @(negedge bclk);
    bus.sample_l_i = l;
    bus.sample_r_i = r;
    bus.data_ready_i = 1'b1;
    @(negedge bclk);
    bus.data_ready_i = 1'b0;
    idle(2);
  endtask

  task automatic rel();
    release_toggle_i = ~release_toggle_i;
    idle(5);
  endtask

  task automatic qclr();
    qa.delete();
    qd.delete();
    qc.delete();
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.wr_en_o), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr_o), 0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data_o), 0);
    chk({tag, "_toggle"}, 32'(frame_toggle_o), 0);
    chk({tag, "_fbank"}, 32'(frame_bank_o), 0);
    chk({tag, "_active"}, 32'(active_bank_o), 0);
    chk({tag, "_ovr"}, 32'(overrun_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dexp[8];
    dexp = '{0, 3, 6, 9, 12, 15, 18, 21};
    bus.sample_l_i = '0;
    bus.sample_r_i = '0;
    bus.data_ready_i = 1'b0;

    // reset state
    idle(3);
    outs_zero("rst");
    rst_n = 1'b1;
    idle(3);

    // mode 0, decim 0: latency 1, addr 0..7, one toggle
    qclr();
    @(negedge bclk);
    bus.sample_l_i = 16'd0;
    bus.sample_r_i = 16'd0;
    bus.data_ready_i = 1'b1;
    chk("lat_pre", 32'(bus.wr_en_o), 0);
    @(negedge bclk);
    bus.data_ready_i = 1'b0;
    chk("lat_wr_en", 32'(bus.wr_en_o), 1);
    chk("lat_addr", 32'(bus.wr_addr_o), 0);
    idle(2);
    for (int n = 1; n < 8; n++) begin
      frame(16'(n), 16'(-n));
      if (n == 6) chk("m0_no_toggle_yet", 32'(frame_toggle_o), 0);
    end
    chk("m0_count", qa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("m0_addr", 32'(qa[k]), 32'(k));
      chk("m0_data", 32'(qd[k]), 32'(k));
    end
    chk("m0_toggle", 32'(frame_toggle_o), 1);
    chk("m0_fbank", 32'(frame_bank_o), 0);
    chk("m0_active", 32'(active_bank_o), 1);
    rel();

    // mode 2: averaging into bank 1
    mode_i = 2'd2;
    idle(4);
    qclr();
    frame(16'h7FFF, 16'h7FFF);
    frame(16'h8000, 16'h8001);
    frame(16'h0001, 16'hFFFE);
    chk("avg_max", 32'(qd[0]), 32'h7FFF);
    chk("avg_min", 32'(qd[1]), 32'h8000);
    chk("avg_floor", 32'(qd[2]), 32'hFFFF);
    chk("avg_addr0", 32'(qa[0]), 8);
    chk("avg_addr2", 32'(qa[2]), 10);
    for (int k = 0; k < 5; k++) frame(16'd0, 16'd0);
    chk("avg_count", qa.size(), 8);
    chk("avg_last_addr", 32'(qa[7]), 15);
    chk("avg_toggle", 32'(frame_toggle_o), 0);
    chk("avg_fbank", 32'(frame_bank_o), 1);
    chk("avg_active", 32'(active_bank_o), 0);
    rel();

    // mode 3: interleaved L/R on consecutive cycles
    mode_i = 2'd3;
    idle(4);
    qclr();
    for (int i = 0; i < 4; i++) begin
      frame(16'(16'h10 + i), 16'(16'h20 + i));
      if (i == 2) chk("il_no_toggle_yet", 32'(frame_toggle_o), 0);
    end
    chk("il_count", qa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("il_addr", 32'(qa[k]), 32'(k));
      chk("il_data", 32'(qd[k]),
          (k % 2 == 0) ? 32'(16'h10 + k / 2) : 32'(16'h20 + k / 2));
    end
    for (int i = 0; i < 4; i++)
      chk("il_consec", 32'(qc[2 * i + 1] - qc[2 * i]), 1);
    chk("il_toggle", 32'(frame_toggle_o), 1);
    chk("il_fbank", 32'(frame_bank_o), 0);
    chk("il_active", 32'(active_bank_o), 1);
    rel();

    // decimation 2, changed to 0 mid-bank
    mode_i = 2'd0;
    decim_i = 4'd2;
    idle(4);
    qclr();
    for (int i = 0; i < 8; i++) frame(16'(16'h100 + i), 16'd0);
    decim_i = 4'd0;
    idle(4);
    for (int i = 8; i < 22; i++) frame(16'(16'h100 + i), 16'd0);
    chk("dec_count", qa.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("dec_addr", 32'(qa[k]), 32'(8 + k));
      chk("dec_data", 32'(qd[k]), 32'(16'h100 + dexp[k]));
    end
    chk("dec_toggle", 32'(frame_toggle_o), 0);
    chk("dec_fbank", 32'(frame_bank_o), 1);
    chk("dec_active", 32'(active_bank_o), 0);
    qclr();
    frame(16'h200, 16'd0);
    frame(16'h201, 16'd0);
    chk("dec0_count", qa.size(), 2);
    chk("dec0_addr1", 32'(qa[1]), 1);
    chk("dec0_data1", 32'(qd[1]), 32'h201);
    for (int i = 2; i < 8; i++) frame(16'(16'h200 + i), 16'd0);
    chk("full_toggle", 32'(frame_toggle_o), 1);
    chk("full_fbank", 32'(frame_bank_o), 0);
    chk("full_active", 32'(active_bank_o), 1);
    chk("full_ovr", 32'(overrun_o), 0);

    // both banks full: stall, overrun, release resumes
    qclr();
    frame(16'h300, 16'd0);
    chk("stall_nowr", qa.size(), 0);
    chk("stall_ovr", 32'(overrun_o), 1);
    frame(16'h301, 16'd0);
    chk("stall_nowr2", qa.size(), 0);
    release_toggle_i = ~release_toggle_i;
    idle(3);
    frame(16'h302, 16'd0);
    chk("resume_count", qa.size(), 1);
    chk("resume_addr", 32'(qa[0]), 8);
    chk("resume_data", 32'(qd[0]), 32'h302);
    chk("resume_ovr_sticky", 32'(overrun_o), 1);
    @(negedge bclk);
    clear_overrun_i = 1'b1;
    @(negedge bclk);
    clear_overrun_i = 1'b0;
    chk("ovr_clear", 32'(overrun_o), 0);

    // reset mid-frame at ptr 5
    release_toggle_i = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    for (int i = 0; i < 5; i++) frame(16'(16'h400 + i), 16'd0);
    chk("pre_rst_toggle", 32'(frame_toggle_o), 0);
    rst_n = 1'b0;
    idle(2);
    outs_zero("midrst");
    rst_n = 1'b1;
    idle(4);
    qclr();
    frame(16'h4AA, 16'd0);
    chk("postrst_count", qa.size(), 1);
    chk("postrst_addr", 32'(qa[0]), 0);
    chk("postrst_data", 32'(qd[0]), 32'h4AA);
    chk("postrst_toggle", 32'(frame_toggle_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
